// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode-stage controller:
// opcode values, immediate-format / result-source / ALU-op enums, the
// packed decode->execute control bundle, its bubble value and the trap FSM states.
package decode_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_PASS   = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_rd;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        pc_a;
    result_src_t result_src;
    alu_op_t     alu_op;
    logic        csr;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    valid:      1'b0,
    reg_wr:     1'b0,
    mem_wr:     1'b0,
    mem_rd:     1'b0,
    branch:     1'b0,
    jump:       1'b0,
    alu_src:    1'b0,
    pc_a:       1'b0,
    result_src: RES_ALU,
    alu_op:     ALU_ADD,
    csr:        1'b0
  };

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_t;

endpackage

// File: rtl/decode_controller_ctrl_decode.sv
// Pure combinational opcode decoder.
//   opcode_i  : inst[6:0]
//   imm_src_o : immediate format select
//   ctrl_o    : control bundle (valid bit always 0; the top qualifies it)
//   legal_o   : opcode is a supported instruction
// Optional feature macro: DECODE_CSR_EN makes SYSTEM a legal CSR instruction.
module ctrl_decode
  import decode_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [2:0]          imm_src_o,
  output ctrl_t               ctrl_o,
  output logic                legal_o
);

  imm_src_t imm_src;

  // Opcode -> controls; anything not listed stays at bubble values.
  always_comb begin
    imm_src = IMM_I;
    ctrl_o  = CTRL_BUBBLE;
    legal_o = 1'b0;
    case (opcode_i)
      OP_LUI: begin
        imm_src = IMM_U; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_PASS;
      end
      OP_AUIPC: begin
        imm_src = IMM_U; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.alu_src = 1'b1; ctrl_o.pc_a = 1'b1;
      end
      OP_JAL: begin
        imm_src = IMM_J; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.jump = 1'b1; ctrl_o.pc_a = 1'b1;
        ctrl_o.alu_src = 1'b1; ctrl_o.result_src = RES_PC4;
      end
      OP_JALR: begin
        imm_src = IMM_I; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.jump = 1'b1; ctrl_o.alu_src = 1'b1;
        ctrl_o.result_src = RES_PC4;
      end
      OP_BRANCH: begin
        imm_src = IMM_B; legal_o = 1'b1;
        ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BRANCH;
      end
      OP_LOAD: begin
        imm_src = IMM_I; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.mem_rd = 1'b1; ctrl_o.alu_src = 1'b1;
        ctrl_o.result_src = RES_MEM;
      end
      OP_STORE: begin
        imm_src = IMM_S; legal_o = 1'b1;
        ctrl_o.mem_wr = 1'b1; ctrl_o.alu_src = 1'b1;
      end
      OP_IMM: begin
        imm_src = IMM_I; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_FUNCT;
      end
      OP_OP: begin
        imm_src = IMM_I; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.alu_op = ALU_FUNCT;
      end
`ifdef DECODE_CSR_EN
      OP_SYSTEM: begin
        imm_src = IMM_I; legal_o = 1'b1;
        ctrl_o.reg_wr = 1'b1; ctrl_o.csr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign imm_src_o = imm_src;

endmodule

// File: rtl/decode_controller.sv
// Decode-stage controller for the 3-stage RV32I pipeline.
// Drives imm_src_d combinationally, registers decoded controls into the
// decode->execute control register (stall/flush aware) and runs a RUN/TRAP
// FSM for illegal opcodes.
//   clk, rst        : clock, synchronous active-high reset
//   inst_d, valid_d : decode-stage instruction and its valid flag
//   stall, flush    : hold / kill the decode->execute transfer
//   trap_ack        : trap handler accepted trap_req
//   imm_src_d       : immediate format (zero latency)
//   *_e             : registered execute-stage controls
//   trap_req, stall_req : asserted while in TRAP
// Optional feature macro: DECODE_CSR_EN (SYSTEM opcode legal, drives csr_e).
module decode_controller
  import decode_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] inst_d,
  input  logic          valid_d,
  input  logic          stall,
  input  logic          flush,
  input  logic          trap_ack,
  output logic [2:0]    imm_src_d,
  output logic          valid_e,
  output logic          reg_wr_e,
  output logic          mem_wr_e,
  output logic          mem_rd_e,
  output logic          branch_e,
  output logic          jump_e,
  output logic          alu_src_e,
  output logic          pc_a_e,
  output logic [1:0]    result_src_e,
  output logic [1:0]    alu_op_e,
  output logic          csr_e,
  output logic          trap_req,
  output logic          stall_req
);

  ctrl_t       dec_ctrl;
  logic        dec_legal;
  ctrl_t       ctrl_q, ctrl_d;
  trap_state_t state_q, state_d;

  // Only the opcode field matters to this controller.
  logic unused_inst;
  assign unused_inst = ^inst_d[DW-1:OPCODE_W];

  ctrl_decode u_decode (
    .opcode_i  (inst_d[OPCODE_W-1:0]),
    .imm_src_o (imm_src_d),
    .ctrl_o    (dec_ctrl),
    .legal_o   (dec_legal)
  );

  // Next-state for trap FSM and control register (flush > stall > load).
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      ST_RUN:  if (valid_d && !dec_legal && !stall && !flush) state_d = ST_TRAP;
      ST_TRAP: if (trap_ack || flush) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    if (flush) begin
      ctrl_d = CTRL_BUBBLE;
    end else if (!stall) begin
      // Only a valid, legal instruction issued in RUN carries controls forward.
      if (valid_d && dec_legal && (state_q == ST_RUN)) begin
        ctrl_d       = dec_ctrl;
        ctrl_d.valid = 1'b1;
      end else begin
        ctrl_d = CTRL_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_e      = ctrl_q.valid;
  assign reg_wr_e     = ctrl_q.reg_wr;
  assign mem_wr_e     = ctrl_q.mem_wr;
  assign mem_rd_e     = ctrl_q.mem_rd;
  assign branch_e     = ctrl_q.branch;
  assign jump_e       = ctrl_q.jump;
  assign alu_src_e    = ctrl_q.alu_src;
  assign pc_a_e       = ctrl_q.pc_a;
  assign result_src_e = ctrl_q.result_src;
  assign alu_op_e     = ctrl_q.alu_op;
  assign csr_e        = ctrl_q.csr;
  assign trap_req     = (state_q == ST_TRAP);
  assign stall_req    = (state_q == ST_TRAP);

endmodule
